// File: rtl/screen_pkg.sv
// Shared definitions for the screen frame-memory arbiter: return-tag encoding
// and frame geometry.
package screen_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int FB_WORDS = 76800;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_B    = 2'd2
  } ret_tag_e;

endpackage

// File: rtl/screen_arb_starve_cnt.sv
// Saturating wait counter for port B; flags when B has waited LIMIT cycles.
// Instantiated by screen_mem_arbiter only when SCREEN_ARB_STARVE_GUARD_EN is defined.
module screen_arb_starve_cnt #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_at_limit
);

  localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || !i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_W'(LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/screen_mem_arbiter.sv
// Single-port frame-memory arbiter: VGA fetch port has priority over port B.
// Define SCREEN_ARB_STARVE_GUARD_EN to enable the B starvation guard and vga_miss.
module screen_mem_arbiter
  import screen_pkg::*;
#(
  parameter int          ADDR_W       = 17,
  parameter int          DATA_W       = 2,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_miss,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              w_force;
  logic              w_gnt_vga;
  logic              w_gnt_b;
  logic              w_miss;
  ret_tag_e          r_tag;
  logic              r_miss;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [DATA_W-1:0] r_vga_rdata;
  logic [DATA_W-1:0] r_b_rdata;

`ifdef SCREEN_ARB_STARVE_GUARD_EN
  logic w_at_limit;

  screen_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_req      (b_req),
    .i_gnt      (w_gnt_b),
    .o_at_limit (w_at_limit)
  );

  assign w_force = w_at_limit & b_req;
  assign w_miss  = vga_req & ~w_gnt_vga & ~rst;
`else
  logic w_unused_limit;
  assign w_unused_limit = (STARVE_LIMIT == 0);
  assign w_force        = 1'b0;
  assign w_miss         = 1'b0;
`endif

  // Grant decision; a cycle with rst high grants nothing, so no read survives reset.
  assign w_gnt_vga = ~rst & vga_req & ~w_force;
  assign w_gnt_b   = ~rst & b_req & (~vga_req | w_force);

  assign b_gnt     = w_gnt_b;
  assign mem_we    = w_gnt_b & b_we;
  assign mem_wdata = b_wdata;

  always_comb begin
    mem_addr = r_addr_hold;
    if (w_gnt_vga) begin
      mem_addr = vga_addr;
    end else if (w_gnt_b) begin
      mem_addr = b_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_gnt_vga || w_gnt_b) begin
      r_addr_hold <= mem_addr;
    end
  end

  // Return-tag stage: data arrives from the RAM one cycle after the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag  <= TAG_NONE;
      r_miss <= 1'b0;
    end else begin
      r_miss <= w_miss;
      if (w_gnt_vga) begin
        r_tag <= TAG_VGA;
      end else if (w_gnt_b && !b_we) begin
        r_tag <= TAG_B;
      end else begin
        r_tag <= TAG_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vga_rdata <= '0;
      r_b_rdata   <= '0;
    end else begin
      if (r_tag == TAG_VGA) begin
        r_vga_rdata <= mem_rdata;
      end
      if (r_tag == TAG_B) begin
        r_b_rdata <= mem_rdata;
      end
    end
  end

  assign vga_rvalid = (r_tag == TAG_VGA);
  assign b_rvalid   = (r_tag == TAG_B);
  assign vga_rdata  = (r_tag == TAG_VGA) ? mem_rdata : r_vga_rdata;
  assign b_rdata    = (r_tag == TAG_B) ? mem_rdata : r_b_rdata;
  assign vga_miss   = r_miss;

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Directed testbench for screen_mem_arbiter; expectations follow
// SCREEN_ARB_STARVE_GUARD_EN when it is defined for the build.
module tb_screen_mem_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 2;

  logic              clk;
  logic              rst;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_miss;
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  screen_mem_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_rvalid (vga_rvalid),
    .vga_rdata  (vga_rdata),
    .vga_miss   (vga_miss),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_gnt      (b_gnt),
    .b_rvalid   (b_rvalid),
    .b_rdata    (b_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (vga_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_vga_rvalid got %0b want 0", vga_rvalid); end
    n_checks++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_b_rvalid got %0b want 0", b_rvalid); end
    n_checks++; if (vga_miss !== 1'b0) begin n_fail++; $display("FAIL reset_vga_miss got %0b want 0", vga_miss); end
    n_checks++; if (vga_rdata !== 2'd0) begin n_fail++; $display("FAIL reset_vga_rdata got %0d want 0", vga_rdata); end
    n_checks++; if (b_rdata !== 2'd0) begin n_fail++; $display("FAIL reset_b_rdata got %0d want 0", b_rdata); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %0b want 0", mem_we); end
    n_checks++; if (b_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_b_gnt got %0b want 0", b_gnt); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_vga_read();
    vga_req  = 1'b1;
    vga_addr = 17'h00010;
    #1;
    n_checks++; if (b_gnt !== 1'b0) begin n_fail++; $display("FAIL vga_rd_b_gnt got %0b want 0", b_gnt); end
    n_checks++; if (mem_addr !== 17'h00010) begin n_fail++; $display("FAIL vga_rd_mem_addr got %h want 00010", mem_addr); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL vga_rd_mem_we got %0b want 0", mem_we); end
    step();
    vga_req   = 1'b0;
    mem_rdata = 2'd2;
    #1;
    n_checks++; if (vga_rvalid !== 1'b1) begin n_fail++; $display("FAIL vga_rd_rvalid got %0b want 1", vga_rvalid); end
    n_checks++; if (vga_rdata !== 2'd2) begin n_fail++; $display("FAIL vga_rd_rdata got %0d want 2", vga_rdata); end
    n_checks++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL vga_rd_b_rvalid got %0b want 0", b_rvalid); end
    step();
    mem_rdata = 2'd1;
    #1;
    n_checks++; if (vga_rvalid !== 1'b0) begin n_fail++; $display("FAIL vga_rd_rvalid_after got %0b want 0", vga_rvalid); end
    n_checks++; if (vga_rdata !== 2'd2) begin n_fail++; $display("FAIL vga_rd_rdata_hold got %0d want 2", vga_rdata); end
    n_checks++; if (vga_miss !== 1'b0) begin n_fail++; $display("FAIL vga_rd_miss got %0b want 0", vga_miss); end
  endtask

  task automatic test_b_read();
    b_req  = 1'b1;
    b_we   = 1'b0;
    b_addr = 17'h12C00;
    #1;
    n_checks++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL b_rd_gnt got %0b want 1", b_gnt); end
    n_checks++; if (mem_addr !== 17'h12C00) begin n_fail++; $display("FAIL b_rd_mem_addr got %h want 12c00", mem_addr); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL b_rd_mem_we got %0b want 0", mem_we); end
    step();
    b_req     = 1'b0;
    mem_rdata = 2'd3;
    #1;
    n_checks++; if (b_rvalid !== 1'b1) begin n_fail++; $display("FAIL b_rd_rvalid got %0b want 1", b_rvalid); end
    n_checks++; if (b_rdata !== 2'd3) begin n_fail++; $display("FAIL b_rd_rdata got %0d want 3", b_rdata); end
    n_checks++; if (vga_rvalid !== 1'b0) begin n_fail++; $display("FAIL b_rd_vga_rvalid got %0b want 0", vga_rvalid); end
    n_checks++; if (mem_addr !== 17'h12C00) begin n_fail++; $display("FAIL idle_mem_addr_hold got %h want 12c00", mem_addr); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_mem_we got %0b want 0", mem_we); end
    n_checks++; if (b_gnt !== 1'b0) begin n_fail++; $display("FAIL idle_b_gnt got %0b want 0", b_gnt); end
    step();
  endtask

  task automatic test_b_write();
    b_req   = 1'b1;
    b_we    = 1'b1;
    b_wdata = 2'd3;
    b_addr  = 17'h00005;
    #1;
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL b_wr_mem_we got %0b want 1", mem_we); end
    n_checks++; if (mem_wdata !== 2'd3) begin n_fail++; $display("FAIL b_wr_mem_wdata got %0d want 3", mem_wdata); end
    n_checks++; if (mem_addr !== 17'h00005) begin n_fail++; $display("FAIL b_wr_mem_addr got %h want 00005", mem_addr); end
    n_checks++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL b_wr_gnt got %0b want 1", b_gnt); end
    step();
    b_req = 1'b0;
    b_we  = 1'b0;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL b_wr_mem_we_after got %0b want 0", mem_we); end
    n_checks++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL b_wr_rvalid got %0b want 0", b_rvalid); end
    step();
    n_checks++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL b_wr_rvalid_late got %0b want 0", b_rvalid); end
  endtask

  task automatic test_starve();
    logic exp_gnt, exp_miss, exp_vrv, exp_brv;
    logic [ADDR_W-1:0] exp_addr;
    mem_rdata = 2'd1;
    vga_addr  = 17'h00456;
    b_addr    = 17'h00123;
    b_we      = 1'b0;
    vga_req   = 1'b1;
    b_req     = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      #1;
`ifdef SCREEN_ARB_STARVE_GUARD_EN
      exp_gnt  = (k == 16);
      exp_miss = (k == 17);
      exp_vrv  = (k >= 2) && (k != 17);
      exp_brv  = (k == 17);
`else
      exp_gnt  = 1'b0;
      exp_miss = 1'b0;
      exp_vrv  = (k >= 2);
      exp_brv  = 1'b0;
`endif
      exp_addr = exp_gnt ? 17'h00123 : 17'h00456;
      n_checks++; if (b_gnt !== exp_gnt) begin n_fail++; $display("FAIL starve_b_gnt cycle %0d got %0b want %0b", k, b_gnt, exp_gnt); end
      n_checks++; if (vga_miss !== exp_miss) begin n_fail++; $display("FAIL starve_vga_miss cycle %0d got %0b want %0b", k, vga_miss, exp_miss); end
      n_checks++; if (vga_rvalid !== exp_vrv) begin n_fail++; $display("FAIL starve_vga_rvalid cycle %0d got %0b want %0b", k, vga_rvalid, exp_vrv); end
      n_checks++; if (b_rvalid !== exp_brv) begin n_fail++; $display("FAIL starve_b_rvalid cycle %0d got %0b want %0b", k, b_rvalid, exp_brv); end
      n_checks++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL starve_mem_addr cycle %0d got %h want %h", k, mem_addr, exp_addr); end
      @(posedge clk);
    end
    #1;
    vga_req = 1'b0;
    b_req   = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_drop();
    vga_req  = 1'b1;
    vga_addr = 17'h00007;
    b_req    = 1'b1;
    b_we     = 1'b1;
    b_wdata  = 2'd2;
    rst      = 1'b1;
    #1;
    n_checks++; if (b_gnt !== 1'b0) begin n_fail++; $display("FAIL rstdrop_b_gnt got %0b want 0", b_gnt); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rstdrop_mem_we got %0b want 0", mem_we); end
    step();
    rst     = 1'b0;
    vga_req = 1'b0;
    b_req   = 1'b0;
    b_we    = 1'b0;
    #1;
    n_checks++; if (vga_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstdrop_vga_rvalid got %0b want 0", vga_rvalid); end
    n_checks++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstdrop_b_rvalid got %0b want 0", b_rvalid); end
    n_checks++; if (vga_miss !== 1'b0) begin n_fail++; $display("FAIL rstdrop_vga_miss got %0b want 0", vga_miss); end
    n_checks++; if (vga_rdata !== 2'd0) begin n_fail++; $display("FAIL rstdrop_vga_rdata got %0d want 0", vga_rdata); end
    n_checks++; if (b_rdata !== 2'd0) begin n_fail++; $display("FAIL rstdrop_b_rdata got %0d want 0", b_rdata); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rstdrop_mem_we_after got %0b want 0", mem_we); end
    n_checks++; if (b_gnt !== 1'b0) begin n_fail++; $display("FAIL rstdrop_b_gnt_after got %0b want 0", b_gnt); end
    step();
  endtask

  initial begin
    rst       = 1'b1;
    vga_req   = 1'b0;
    vga_addr  = '0;
    b_req     = 1'b0;
    b_we      = 1'b0;
    b_addr    = '0;
    b_wdata   = '0;
    mem_rdata = '0;
    test_reset();
    test_vga_read();
    test_b_read();
    test_b_write();
    test_starve();
    test_reset_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
